range_reader: RTL and testbench
===============================

Name: range_reader

Overview:
- Host-side reader for the Collatz range block.
- On a request it launches a range fill at a given base number, waits for the fill to finish, then reads every RAM word back through the range block's read port (done/start/count).
- It streams each (n, count) pair out on a valid/ready interface toward the display/bus logic.
- It is the consumer of the range RAM's write-then-read protocol.

Parameters:
- RAM_WORDS, 16: number of counts held by the range block; the reader reads exactly this many.
- RAM_ADDR_BITS, 4: address width of the range RAM; RAM_WORDS <= 2**RAM_ADDR_BITS.

Ports:
- clk, input, 1: clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- req, input, 1: start request; sampled only in S_IDLE.
- base, input, 32: first Collatz start number; latched when req is accepted.
- busy, output, 1: high in every state except S_IDLE.
- fin, output, 1: one-cycle pulse after the last word is handed off.
- rgo, output, 1: go to range; one-cycle pulse.
- rstart, output, 32: to range start; base in S_LAUNCH, zero-extended read address otherwise.
- rdone, input, 1: done from range.
- rcount, input, 16: count from range; registered read, valid one cycle after the address is presented.
- out_valid, output, 1: out_n/out_count/out_last are valid.
- out_ready, input, 1: sink accepts the word when out_valid && out_ready.
- out_n, output, 32: start number of this word (base_q + idx, mod 2^32).
- out_count, output, 16: Collatz iteration count read from RAM.
- out_last, output, 1: high with the word for idx == RAM_WORDS-1.

Behaviour:
- Reset:
  - state=S_IDLE, idx=0, base_q=0.
  - busy, fin, rgo, out_valid, out_last = 0; rstart, out_n, out_count = 0.
- State machine. Registered outputs; idx is RAM_ADDR_BITS wide.
  - S_IDLE: if req, then base_q<=base, idx<=0, go to S_LAUNCH. Otherwise hold. rstart=0.
  - S_LAUNCH (1 cycle): rgo=1, rstart=base_q. Go to S_ARM.
  - S_ARM: rgo=0. Wait for rdone==0, which discards a stale done left from a prior run (range clears done one cycle after go). Go to S_WAIT.
  - S_WAIT: wait for rdone==1. Then go to S_ADDR.
  - S_ADDR (1 cycle): rstart={zeros,idx}. Go to S_CAPTURE.
  - S_CAPTURE (1 cycle): rstart held. On the edge leaving this state: out_count<=rcount, out_n<=base_q+idx, out_last<=(idx==RAM_WORDS-1), out_valid<=1. Go to S_OUT.
  - S_OUT: outputs held stable while out_valid && !out_ready. On the handshake, out_valid<=0, then:
    - if out_last, go to S_FIN;
    - else idx<=idx+1 and go to S_ADDR.
  - S_FIN (1 cycle): fin=1. Go to S_IDLE.
- rgo is never asserted outside S_LAUNCH. Range treats go in its done state as a restart, so a spurious go would corrupt the RAM mid-readout.
- Latency and throughput:
  - req to first out_valid = 5 cycles + fill time (rdone rise).
  - Minimum 3 cycles per word when out_ready is held high.
- out_valid may not drop without a handshake. Data may not change while out_valid=1.
- req while busy is ignored; no queuing. req held high re-launches immediately after S_FIN→S_IDLE.
- out_n arithmetic: 32-bit wrap (base 0xFFFFFFFF, idx 1 gives 0x00000000).
- Reset mid-operation: synchronous return to the reset values above. The sequence is aborted and no fin is produced. The system requirement is that range and range_reader share reset; there is no timeout.
- rdone dropping during S_ADDR/S_CAPTURE/S_OUT is ignored (range only drops done on go, which this block controls).

Test Plan:
- Basic readout: reset, req with base=1, behavioural range model (count for n=1..16 = 0,1,7,2,5,8,16,3,19,6,14,9,9,17,17,4), out_ready=1 → 16 words, out_n=1..16 with matching counts, out_last only on n=16, fin pulses once, busy low after.
- Backpressure: out_ready random 30% duty → word order and values unchanged, outputs stable while stalled, no dropped or duplicated words.
- Stale done: model holds rdone=1 from a previous run when req arrives → reader waits for the rdone low then high, and reads the new base=27 data (first out_count=111).
- Single go: count rgo pulses across a full run with out_ready stalls → exactly 1, with rstart=base in that cycle; rstart ≤ 15 during readout.
- Wrap and ignore: base=0xFFFFFFF8 → out_n runs 0xFFFFFFF8..0x00000007. A req asserted mid-run is ignored.
- Reset mid-readout: assert reset during the 5th S_OUT → all outputs 0 next cycle, no fin. A following req runs a full clean sequence.

Source files
------------

// File: rtl/range_reader_if.sv
// Word stream from the range reader toward the display/bus logic.
// The master presents (n, count, last) under valid; the slave answers with ready.
interface range_reader_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_n;
  logic [15:0] out_count;
  logic        out_last;

  modport master (
    output out_valid,
    output out_n,
    output out_count,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_n,
    input  out_count,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/range_reader.sv
// Host-side reader for the Collatz range block: launches one fill, then reads
// every RAM word back through the range read port and streams (n, count) pairs.
//
// state     | meaning
// S_IDLE    | waiting for req; rstart parked at 0
// S_LAUNCH  | one-cycle go pulse, rstart = latched base
// S_ARM     | wait for rdone low (discards a done left over from a prior run)
// S_WAIT    | wait for rdone high (fill finished)
// S_ADDR    | present read address idx on rstart
// S_CAPTURE | registered RAM data arrives; load the output word
// S_OUT     | hold the word until out_ready
// S_FIN     | one-cycle fin pulse
module range_reader #(
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [31:0]           base,
  output logic                  busy,
  output logic                  fin,
  output logic                  rgo,
  output logic [31:0]           rstart,
  input  logic                  rdone,
  input  logic [15:0]           rcount,
  range_reader_if.master        out_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_ADDR,
    S_CAPTURE,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state;
  logic [31:0]              base_q;
  logic [RAM_ADDR_BITS-1:0] idx;

  function automatic logic [31:0] addr_ext(input logic [RAM_ADDR_BITS-1:0] a);
    return {{(32 - RAM_ADDR_BITS){1'b0}}, a};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      base_q           <= '0;
      idx              <= '0;
      busy             <= 1'b0;
      fin              <= 1'b0;
      rgo              <= 1'b0;
      rstart           <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_n     <= '0;
      out_if.out_count <= '0;
      out_if.out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rstart <= '0;
          if (req) begin
            base_q <= base;
            idx    <= '0;
            busy   <= 1'b1;
            rgo    <= 1'b1;
            rstart <= base;
            state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          rgo    <= 1'b0;
          rstart <= addr_ext(idx);
          state  <= S_ARM;
        end
        S_ARM: begin
          if (!rdone) state <= S_WAIT;
        end
        S_WAIT: begin
          if (rdone) begin
            rstart <= addr_ext(idx);
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          out_if.out_count <= rcount;
          out_if.out_n     <= base_q + addr_ext(idx);
          out_if.out_last  <= (idx == LAST_IDX);
          out_if.out_valid <= 1'b1;
          state            <= S_OUT;
        end
        S_OUT: begin
          // Word fields stay frozen after the handshake; only valid drops.
          if (out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
            if (out_if.out_last) begin
              fin   <= 1'b1;
              state <= S_FIN;
            end else begin
              idx    <= idx + 1'b1;
              rstart <= addr_ext(idx + 1'b1);
              state  <= S_ADDR;
            end
          end
        end
        S_FIN: begin
          fin    <= 1'b0;
          busy   <= 1'b0;
          rstart <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_reader.sv
// Self-checking bench for range_reader: behavioural range block, word scoreboard,
// table-driven runs, random runs, and a reset-mid-readout sequence.
module tb_range_reader;

  localparam int WORDS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [31:0] base = '0;
  logic        busy, fin, rgo;
  logic [31:0] rstart;
  logic        rdone;
  logic [15:0] rcount;

  range_reader_if bus ();

  range_reader #(.RAM_WORDS(WORDS), .RAM_ADDR_BITS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .base   (base),
    .busy   (busy),
    .fin    (fin),
    .rgo    (rgo),
    .rstart (rstart),
    .rdone  (rdone),
    .rcount (rcount),
    .out_if (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Collatz step count, computed directly from the definition.
  function automatic logic [15:0] collatz(input logic [31:0] n);
    longint unsigned x;
    int c;
    x = 64'(n);
    c = 0;
    if (n == 0) return 16'd0;
    while (x != 1 && c < 65535) begin
      x = x[0] ? (3 * x + 1) : (x >> 1);
      c++;
    end
    return 16'(c);
  endfunction

  // Behavioural range block: go latches start, done drops a cycle later,
  // fill takes a random time, then the RAM holds counts for start..start+15.
  logic [31:0] m_start;
  logic        m_pend;
  int          m_fill;
  logic [15:0] m_ram [WORDS] = '{default: 16'd0};

  always @(posedge clk) begin
    if (reset) begin
      rdone  <= 1'b0;
      rcount <= '0;
      m_pend <= 1'b0;
      m_fill <= 0;
    end else begin
      rcount <= m_ram[rstart[3:0]];
      if (rgo) begin
        m_start <= rstart;
        m_pend  <= 1'b1;
      end else if (m_pend) begin
        m_pend <= 1'b0;
        rdone  <= 1'b0;
        m_fill <= int'($urandom_range(12, 3));
      end else if (m_fill > 0) begin
        m_fill <= m_fill - 1;
        if (m_fill == 1) begin
          for (int i = 0; i < WORDS; i++) m_ram[i] <= collatz(m_start + 32'(i));
          rdone <= 1'b1;
        end
      end
    end
  end

  // Sink ready: random duty, or forced low.
  int ready_pct   = 100;
  bit hold_ready  = 1'b0;
  initial bus.out_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    bus.out_ready = hold_ready ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
  end

  typedef struct {
    logic [31:0] n;
    logic [15:0] c;
    logic        l;
  } word_t;

  word_t       exp_q [$];
  logic [31:0] got_n [$];
  logic [15:0] got_c [$];
  int          go_cnt  = 0;
  int          fin_cnt = 0;
  logic [31:0] exp_base = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] p_n;
  logic [15:0] p_c;
  logic        p_l;

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (rgo) begin
        go_cnt++;
        chk("rgo_rstart", 64'(rstart), 64'(exp_base));
        chk("rgo_busy", 64'(busy), 64'd1);
      end else if (busy) begin
        chk("rstart_range", 64'(rstart < 32'(WORDS)), 64'd1);
      end
      if (fin) begin
        fin_cnt++;
        chk("fin_after_last", 64'(exp_q.size()), 64'd0);
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_n", 64'(bus.out_n), 64'(p_n));
        chk("hold_count", 64'(bus.out_count), 64'(p_c));
        chk("hold_last", 64'(bus.out_last), 64'(p_l));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_word actual_n=%0h required=none", bus.out_n);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_n", 64'(bus.out_n), 64'(w.n));
          chk("word_count", 64'(bus.out_count), 64'(w.c));
          chk("word_last", 64'(bus.out_last), 64'(w.l));
        end
        got_n.push_back(bus.out_n);
        got_c.push_back(bus.out_count);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      p_n = bus.out_n;
      p_c = bus.out_count;
      p_l = bus.out_last;
      if (req && !busy) begin
        exp_base = base;
        for (int i = 0; i < WORDS; i++) begin
          word_t w;
          w.n = base + 32'(i);
          w.c = collatz(base + 32'(i));
          w.l = (i == WORDS - 1);
          exp_q.push_back(w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_fin"}, 64'(fin), 64'd0);
    chk({tag, "_rgo"}, 64'(rgo), 64'd0);
    chk({tag, "_rstart"}, 64'(rstart), 64'd0);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_n"}, 64'(bus.out_n), 64'd0);
    chk({tag, "_count"}, 64'(bus.out_count), 64'd0);
    chk({tag, "_last"}, 64'(bus.out_last), 64'd0);
  endtask

  task automatic run_seq(input logic [31:0] b, input int pct, input bit mid_req);
    int fin0, go0, to;
    fin0 = fin_cnt;
    go0  = go_cnt;
    got_n.delete();
    got_c.delete();
    ready_pct = pct;
    step();
    req  = 1'b1;
    base = b;
    step();
    req  = 1'b0;
    base = $urandom;
    to = 0;
    while (fin_cnt == fin0 && to < 3000) begin
      step();
      to++;
      if (mid_req && to == 30) begin
        req  = 1'b1;
        base = 32'h1234_5678;
      end else begin
        req = 1'b0;
      end
    end
    chk("run_timeout", 64'(to < 3000), 64'd1);
    step();
    chk("busy_after", 64'(busy), 64'd0);
    chk("go_pulses", 64'(go_cnt - go0), 64'd1);
    chk("fin_pulses", 64'(fin_cnt - fin0), 64'd1);
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("words_seen", 64'(got_n.size()), 64'(WORDS));
  endtask

  typedef struct {
    logic [31:0] base;
    int          pct;
    bit          mid_req;
    bit          chk_first;
    logic [15:0] first_cnt;
    logic [31:0] last_n;
  } vec_t;

  vec_t tbl [4];
  logic [15:0] cnt_1_16 [WORDS];

  initial begin
    int fin0, to;

    tbl[0] = '{32'd1,          100, 1'b0, 1'b1, 16'd0,   32'd16};
    tbl[1] = '{32'd27,         30,  1'b0, 1'b1, 16'd111, 32'd42};
    tbl[2] = '{32'hFFFF_FFF8,  30,  1'b1, 1'b0, 16'd0,   32'h0000_0007};
    tbl[3] = '{32'd1000,       50,  1'b0, 1'b0, 16'd0,   32'd1015};
    cnt_1_16 = '{16'd0, 16'd1, 16'd7, 16'd2, 16'd5, 16'd8, 16'd16, 16'd3,
                 16'd19, 16'd6, 16'd14, 16'd9, 16'd9, 16'd17, 16'd17, 16'd4};

    repeat (3) step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    chk_zero("idle");

    // Table-driven runs; entry 1 starts with done still high from entry 0.
    for (int k = 0; k < 4; k++) begin
      run_seq(tbl[k].base, tbl[k].pct, tbl[k].mid_req);
      if (got_n.size() == WORDS) begin
        chk("first_n", 64'(got_n[0]), 64'(tbl[k].base));
        chk("last_n", 64'(got_n[WORDS-1]), 64'(tbl[k].last_n));
        if (tbl[k].chk_first) chk("first_count", 64'(got_c[0]), 64'(tbl[k].first_cnt));
        if (k == 0)
          for (int i = 0; i < WORDS; i++) chk("count_1_16", 64'(got_c[i]), 64'(cnt_1_16[i]));
        if (k == 2) chk("wrap_n9", 64'(got_n[8]), 64'd0);
      end
    end

    // Random bases and sink duty.
    for (int r = 0; r < 4; r++)
      run_seq($urandom, int'($urandom_range(100, 20)), 1'b0);

    // Reset during the fifth word's output phase.
    fin0 = fin_cnt;
    got_n.delete();
    got_c.delete();
    ready_pct = 100;
    step();
    req  = 1'b1;
    base = 32'd200;
    step();
    req = 1'b0;
    to = 0;
    while (!(got_n.size() == 4 && bus.out_valid) && to < 500) begin
      step();
      to++;
    end
    chk("mid_reset_reach", 64'(to < 500), 64'd1);
    hold_ready = 1'b1;
    reset      = 1'b1;
    step();
    chk_zero("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    hold_ready = 1'b0;
    repeat (20) step();
    chk("no_fin_after_reset", 64'(fin_cnt), 64'(fin0));
    chk("idle_after_reset", 64'(busy), 64'd0);
    run_seq(32'd77, 100, 1'b0);
    if (got_n.size() == WORDS) chk("clean_first_n", 64'(got_n[0]), 64'd77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
